// File: rtl/macload_csr_regs_pkg.sv
// Local constants and decode helpers for the MAC-load CSR block.
package macload_csr_regs_pkg;
    import riscv_defines::*;

    // Storage registers are indexed by addr[3:0]; even = activation, odd = weight.
    localparam int unsigned NUM_DATA_REGS = 8;
    localparam logic [3:0]  STATUS_IDX    = 4'd8;
    localparam logic [7:0]  A_SIDE_MASK   = 8'h55;
    localparam logic [7:0]  W_SIDE_MASK   = 8'hAA;

    function automatic logic csr_in_range(input logic [11:0] addr);
        return (addr >= CSR_A_ADDR) && (addr <= CSR_ML_STATUS);
    endfunction

endpackage

// File: rtl/riscv_defines.sv
// Shared CSR operation encodings and the MAC-load CSR address map.
package riscv_defines;

    localparam logic [1:0] CSR_OP_NONE  = 2'b00;
    localparam logic [1:0] CSR_OP_WRITE = 2'b01;
    localparam logic [1:0] CSR_OP_SET   = 2'b10;
    localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

    localparam logic [11:0] CSR_A_ADDR     = 12'h800;
    localparam logic [11:0] CSR_W_ADDR     = 12'h801;
    localparam logic [11:0] CSR_A_STRIDE   = 12'h802;
    localparam logic [11:0] CSR_W_STRIDE   = 12'h803;
    localparam logic [11:0] CSR_A_ROLLBACK = 12'h804;
    localparam logic [11:0] CSR_W_ROLLBACK = 12'h805;
    localparam logic [11:0] CSR_A_SKIP     = 12'h806;
    localparam logic [11:0] CSR_W_SKIP     = 12'h807;
    localparam logic [11:0] CSR_ML_STATUS  = 12'h808;

endpackage

// File: rtl/macload_csr_regs_if.sv
// Software CSR access port plus the controller's address-update port.
interface macload_csr_regs_if;
    logic [1:0]  sw_op_i;
    logic [11:0] sw_addr_i;
    logic [31:0] sw_wdata_i;
    logic [31:0] sw_rdata_o;
    logic        sw_hit_o;
    logic [1:0]  hw_op_i;
    logic [11:0] hw_addr_i;
    logic [31:0] hw_wdata_i;

    modport master (
        output sw_op_i, sw_addr_i, sw_wdata_i, hw_op_i, hw_addr_i, hw_wdata_i,
        input  sw_rdata_o, sw_hit_o
    );

    modport slave (
        input  sw_op_i, sw_addr_i, sw_wdata_i, hw_op_i, hw_addr_i, hw_wdata_i,
        output sw_rdata_o, sw_hit_o
    );
endinterface

// File: rtl/macload_csr_reg.sv
// One 32-bit CSR with WRITE/SET/CLEAR read-modify-write decode.
module macload_csr_reg
    import riscv_defines::*;
#(
    parameter logic [31:0] RST_VAL = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] q_o
);

    logic [31:0] reg_q;
    logic [31:0] reg_d;

    // NOTE: default assignment first so every path assigns reg_d; no latch.
    always_comb begin
        reg_d = reg_q;
        case (op_i)
            CSR_OP_WRITE: reg_d = wdata_i;
            CSR_OP_SET:   reg_d = reg_q | wdata_i;
            CSR_OP_CLEAR: reg_d = reg_q & ~wdata_i;
            default:      reg_d = reg_q;
        endcase
    end

    // NOTE: non-blocking assignment for flop state avoids simulation races.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) reg_q <= RST_VAL;
        else       reg_q <= reg_d;
    end

    assign q_o = reg_q;

endmodule

// File: rtl/macload_csr_regs.sv
// MAC-load CSR bank: activation/weight address-walk registers, W1C collision status,
// and per-side update-counter clear pulses for the MAC-load controller.
module macload_csr_regs
    import riscv_defines::*;
    import macload_csr_regs_pkg::*;
#(
    parameter logic [31:0] A_RST_ADDR = 32'h0000_0000,
    parameter logic [31:0] W_RST_ADDR = 32'h0000_0000
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    macload_csr_regs_if.slave         bus,
    output logic [31:0]               a_address_o,
    output logic [31:0]               a_stride_o,
    output logic [31:0]               a_rollback_o,
    output logic [31:0]               a_skip_o,
    output logic [31:0]               w_address_o,
    output logic [31:0]               w_stride_o,
    output logic [31:0]               w_rollback_o,
    output logic [31:0]               w_skip_o,
    output logic                      csr_a_rstn_o,
    output logic                      csr_w_rstn_o
);

    logic        sw_hit;
    logic        sw_active;
    logic [3:0]  sw_idx;
    logic [7:0]  sw_sel;
    logic        hw_wr_a;
    logic        hw_wr_w;
    logic [1:0]  collision;
    logic [1:0]  status_clr;
    logic [31:0] status_d;
    logic [31:0] status_val;
    logic [31:0] reg_val [NUM_DATA_REGS];
    logic [31:0] sw_rdata;
    logic        a_rstn_q, a_rstn_d;
    logic        w_rstn_q, w_rstn_d;

    assign sw_idx    = bus.sw_addr_i[3:0];
    assign sw_hit    = csr_in_range(bus.sw_addr_i);
    assign sw_active = sw_hit && (bus.sw_op_i != CSR_OP_NONE);
    assign hw_wr_a   = (bus.hw_op_i == CSR_OP_WRITE) && (bus.hw_addr_i == CSR_A_ADDR);
    assign hw_wr_w   = (bus.hw_op_i == CSR_OP_WRITE) && (bus.hw_addr_i == CSR_W_ADDR);

    for (genvar i = 0; i < NUM_DATA_REGS; i++) begin : g_reg
        localparam logic [31:0] RST_VAL = (i == 0) ? A_RST_ADDR :
                                          (i == 1) ? W_RST_ADDR : 32'h0;
        logic        hw_sel;
        logic [1:0]  op;
        logic [31:0] wdata;

        assign sw_sel[i] = sw_active && (sw_idx == 4'(i));
        assign hw_sel    = (i == 0) ? hw_wr_a : (i == 1) ? hw_wr_w : 1'b0;
        // Software wins a same-cycle conflict; the hardware value is dropped.
        assign op        = sw_sel[i] ? bus.sw_op_i  : (hw_sel ? CSR_OP_WRITE : CSR_OP_NONE);
        assign wdata     = sw_sel[i] ? bus.sw_wdata_i : bus.hw_wdata_i;

        macload_csr_reg #(.RST_VAL(RST_VAL)) u_reg (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .op_i    (op),
            .wdata_i (wdata),
            .q_o     (reg_val[i])
        );
    end

    assign collision  = {hw_wr_w && sw_sel[1], hw_wr_a && sw_sel[0]};
    assign status_clr = (sw_hit && (sw_idx == STATUS_IDX) &&
                         ((bus.sw_op_i == CSR_OP_WRITE) || (bus.sw_op_i == CSR_OP_SET)))
                        ? bus.sw_wdata_i[1:0] : 2'b00;
    // Set takes priority over W1C so a collision is never lost.
    assign status_d   = {30'b0, (status_val[1:0] & ~status_clr) | collision};

    macload_csr_reg #(.RST_VAL(32'h0)) u_status (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .op_i    (CSR_OP_WRITE),
        .wdata_i (status_d),
        .q_o     (status_val)
    );

    always_comb begin
        sw_rdata = 32'h0;
        if (sw_hit) begin
            if (sw_idx == STATUS_IDX) sw_rdata = status_val;
            else                      sw_rdata = reg_val[sw_idx[2:0]];
        end
    end

    assign a_rstn_d = ~|(sw_sel & A_SIDE_MASK);
    assign w_rstn_d = ~|(sw_sel & W_SIDE_MASK);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_rstn_q <= 1'b0;
            w_rstn_q <= 1'b0;
        end else begin
            a_rstn_q <= a_rstn_d;
            w_rstn_q <= w_rstn_d;
        end
    end

    assign bus.sw_hit_o   = sw_hit;
    assign bus.sw_rdata_o = sw_rdata;
    assign a_address_o    = reg_val[0];
    assign w_address_o    = reg_val[1];
    assign a_stride_o     = reg_val[2];
    assign w_stride_o     = reg_val[3];
    assign a_rollback_o   = reg_val[4];
    assign w_rollback_o   = reg_val[5];
    assign a_skip_o       = reg_val[6];
    assign w_skip_o       = reg_val[7];
    assign csr_a_rstn_o   = a_rstn_q;
    assign csr_w_rstn_o   = w_rstn_q;

endmodule

// File: tb/tb_macload_csr_regs.sv
// Self-checking bench for macload_csr_regs: directed scenarios plus randomized ops
// compared against an array-based reference model of the CSR bank.
module tb_macload_csr_regs;
    import riscv_defines::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] a_address_o, a_stride_o, a_rollback_o, a_skip_o;
    logic [31:0] w_address_o, w_stride_o, w_rollback_o, w_skip_o;
    logic        csr_a_rstn_o, csr_w_rstn_o;

    always #5 clk_i = ~clk_i;

    macload_csr_regs_if bus ();

    macload_csr_regs #(
        .A_RST_ADDR (32'h1000),
        .W_RST_ADDR (32'h0)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .bus          (bus),
        .a_address_o  (a_address_o),
        .a_stride_o   (a_stride_o),
        .a_rollback_o (a_rollback_o),
        .a_skip_o     (a_skip_o),
        .w_address_o  (w_address_o),
        .w_stride_o   (w_stride_o),
        .w_rollback_o (w_rollback_o),
        .w_skip_o     (w_skip_o),
        .csr_a_rstn_o (csr_a_rstn_o),
        .csr_w_rstn_o (csr_w_rstn_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: index = address - 0x800 (0..7 storage, 8 status).
    bit [31:0] m_reg [8];
    bit [31:0] m_status;
    bit        m_a_rstn, m_w_rstn;

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wd;
        logic [1:0]  hop;
        logic [11:0] haddr;
        logic [31:0] hwd;
    } step_t;

    logic [290:0] obs_vec;
    assign obs_vec = {a_address_o, a_stride_o, a_rollback_o, a_skip_o,
                      w_address_o, w_stride_o, w_rollback_o, w_skip_o,
                      csr_a_rstn_o, csr_w_rstn_o, bus.sw_hit_o, bus.sw_rdata_o};

    task automatic model_reset();
        foreach (m_reg[i]) m_reg[i] = 32'h0;
        m_reg[0] = 32'h1000;
        m_status = 32'h0;
        m_a_rstn = 1'b0;
        m_w_rstn = 1'b0;
    endtask

    function automatic bit [31:0] model_read(input logic [11:0] a);
        int idx = int'(a) - 'h800;
        if (idx >= 0 && idx < 8) return m_reg[idx];
        if (idx == 8)            return m_status;
        return 32'h0;
    endfunction

    function automatic logic [290:0] model_vec();
        int idx = int'(bus.sw_addr_i) - 'h800;
        bit hit = (idx >= 0) && (idx <= 8);
        return {m_reg[0], m_reg[2], m_reg[4], m_reg[6], m_reg[1], m_reg[3], m_reg[5], m_reg[7],
                m_a_rstn, m_w_rstn, hit, model_read(bus.sw_addr_i)};
    endfunction

    // One clock of the CSR rules, evaluated on the inputs present at the edge.
    task automatic model_step();
        bit [31:0] nxt [8];
        bit [1:0]  coll = 2'b00;
        bit [1:0]  clr  = 2'b00;
        int        si   = int'(bus.sw_addr_i) - 'h800;
        int        hi   = int'(bus.hw_addr_i) - 'h800;
        bit        sw_act = (bus.sw_op_i != CSR_OP_NONE) && (si >= 0) && (si <= 8);
        nxt = m_reg;
        if (sw_act && si < 8) begin
            case (bus.sw_op_i)
                CSR_OP_WRITE: nxt[si] = bus.sw_wdata_i;
                CSR_OP_SET:   nxt[si] = m_reg[si] | bus.sw_wdata_i;
                default:      nxt[si] = m_reg[si] & ~bus.sw_wdata_i;
            endcase
        end
        if (sw_act && si == 8 && (bus.sw_op_i == CSR_OP_WRITE || bus.sw_op_i == CSR_OP_SET))
            clr = bus.sw_wdata_i[1:0];
        if (bus.hw_op_i == CSR_OP_WRITE && (hi == 0 || hi == 1)) begin
            if (sw_act && si == hi) coll[hi] = 1'b1;
            else                    nxt[hi]  = bus.hw_wdata_i;
        end
        m_status = (m_status & ~{30'b0, clr}) | {30'b0, coll};
        m_a_rstn = !(sw_act && si < 8 && (si % 2) == 0);
        m_w_rstn = !(sw_act && si < 8 && (si % 2) == 1);
        m_reg    = nxt;
    endtask

    task automatic drive(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                         input logic [1:0] hop, input logic [11:0] haddr, input logic [31:0] hwd);
        bus.sw_op_i    = op;
        bus.sw_addr_i  = addr;
        bus.sw_wdata_i = wd;
        bus.hw_op_i    = hop;
        bus.hw_addr_i  = haddr;
        bus.hw_wdata_i = hwd;
    endtask

    task automatic clock_op();
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        drive(CSR_OP_NONE, 12'h800, 32'h0, CSR_OP_NONE, 12'h0, 32'h0);
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        n_tests++;
        if (obs_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs_vec, model_vec());
        end
        n_tests++;
        if (a_address_o !== 32'h1000 || w_address_o !== 32'h0 || csr_a_rstn_o !== 1'b0 || csr_w_rstn_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: a_addr=%h w_addr=%h rstn=%b%b expected 00001000 00000000 00",
                     a_address_o, w_address_o, csr_a_rstn_o, csr_w_rstn_o);
        end
        rst_i = 1'b0;
        clock_op();
        n_tests++;
        if (csr_a_rstn_o !== 1'b1 || csr_w_rstn_o !== 1'b1 || obs_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected %h", obs_vec, model_vec());
        end
    endtask

    task automatic test_directed();
        step_t s [13];
        s[0]  = '{CSR_OP_WRITE, 12'h800, 32'h2000,     CSR_OP_NONE,  12'h000, 32'h0};
        s[1]  = '{CSR_OP_NONE,  12'h801, 32'h0,        CSR_OP_WRITE, 12'h801, 32'h3040};
        s[2]  = '{CSR_OP_NONE,  12'h802, 32'h0,        CSR_OP_WRITE, 12'h802, 32'h1234};
        s[3]  = '{CSR_OP_WRITE, 12'h800, 32'hA0,       CSR_OP_WRITE, 12'h800, 32'hB0};
        s[4]  = '{CSR_OP_WRITE, 12'h808, 32'h1,        CSR_OP_NONE,  12'h000, 32'h0};
        s[5]  = '{CSR_OP_WRITE, 12'h806, 32'h0F,       CSR_OP_NONE,  12'h000, 32'h0};
        s[6]  = '{CSR_OP_SET,   12'h806, 32'hF0,       CSR_OP_NONE,  12'h000, 32'h0};
        s[7]  = '{CSR_OP_CLEAR, 12'h806, 32'h0F,       CSR_OP_NONE,  12'h000, 32'h0};
        s[8]  = '{CSR_OP_WRITE, 12'h900, 32'hFFFF,     CSR_OP_NONE,  12'h000, 32'h0};
        s[9]  = '{CSR_OP_WRITE, 12'h801, 32'h55,       CSR_OP_WRITE, 12'h800, 32'h66};
        s[10] = '{CSR_OP_SET,   12'h801, 32'h1,        CSR_OP_WRITE, 12'h801, 32'h77};
        s[11] = '{CSR_OP_CLEAR, 12'h808, 32'h3,        CSR_OP_NONE,  12'h000, 32'h0};
        s[12] = '{CSR_OP_SET,   12'h808, 32'h2,        CSR_OP_NONE,  12'h000, 32'h0};
        for (int i = 0; i < 13; i++) begin
            drive(s[i].op, s[i].addr, s[i].wd, s[i].hop, s[i].haddr, s[i].hwd);
            #1;
            n_tests++;
            if (obs_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL directed_pre[%0d]: got %h expected %h", i, obs_vec, model_vec());
            end
            if (i == 6) begin
                n_tests++;
                if (bus.sw_rdata_o !== 32'h0F) begin
                    n_fail++;
                    $display("FAIL skip_prewrite_read: got %h expected 0000000f", bus.sw_rdata_o);
                end
            end
            clock_op();
            n_tests++;
            if (obs_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL directed_post[%0d]: got %h expected %h", i, obs_vec, model_vec());
            end
            if (i == 0) begin
                n_tests++;
                if (a_address_o !== 32'h2000 || csr_a_rstn_o !== 1'b0 || csr_w_rstn_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sw_write_a: a_addr=%h rstn=%b%b expected 00002000 01", a_address_o, csr_a_rstn_o, csr_w_rstn_o);
                end
            end
            if (i == 1 || i == 2) begin
                n_tests++;
                if (w_address_o !== 32'h3040 || a_stride_o !== 32'h0 || csr_a_rstn_o !== 1'b1 || csr_w_rstn_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL hw_write[%0d]: w_addr=%h a_stride=%h rstn=%b%b expected 00003040 00000000 11",
                             i, w_address_o, a_stride_o, csr_a_rstn_o, csr_w_rstn_o);
                end
            end
            if (i == 3) begin
                n_tests++;
                if (a_address_o !== 32'hA0 || dut.status_val !== 32'h1) begin
                    n_fail++;
                    $display("FAIL collision_a: a_addr=%h status=%h expected 000000a0 00000001", a_address_o, dut.status_val);
                end
            end
            if (i == 6 || i == 7) begin
                n_tests++;
                if (a_skip_o !== ((i == 6) ? 32'hFF : 32'hF0)) begin
                    n_fail++;
                    $display("FAIL skip_setclr[%0d]: got %h expected %h", i, a_skip_o, (i == 6) ? 32'hFF : 32'hF0);
                end
            end
            if (i == 8) begin
                n_tests++;
                if (bus.sw_hit_o !== 1'b0 || bus.sw_rdata_o !== 32'h0) begin
                    n_fail++;
                    $display("FAIL read_miss: hit=%b rdata=%h expected 0 00000000", bus.sw_hit_o, bus.sw_rdata_o);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] seq [6] = '{12'h800, 12'h802, 12'h804, 12'h801, 12'h803, 12'h807};
        for (int i = 0; i < 6; i++) begin
            drive(CSR_OP_WRITE, seq[i], $urandom, CSR_OP_NONE, 12'h0, 32'h0);
            clock_op();
            n_tests++;
            if (csr_a_rstn_o !== (i >= 3) || csr_w_rstn_o !== (i < 3) || obs_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %h expected %h", i, obs_vec, model_vec());
            end
        end
        drive(CSR_OP_NONE, 12'h800, 32'h0, CSR_OP_NONE, 12'h0, 32'h0);
        clock_op();
        n_tests++;
        if (csr_a_rstn_o !== 1'b1 || csr_w_rstn_o !== 1'b1) begin
            n_fail++;
            $display("FAIL back_to_back_idle: rstn=%b%b expected 11", csr_a_rstn_o, csr_w_rstn_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int unsigned r = $urandom_range(0, 10);
            logic [11:0] sa = (r < 9) ? 12'(12'h800 + r) : ((r == 9) ? 12'h7FF : 12'h900);
            drive(2'($urandom_range(0, 3)), sa, $urandom,
                  2'($urandom_range(0, 3)), 12'(12'h800 + $urandom_range(0, 2)), $urandom);
            #1;
            n_tests++;
            if (obs_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL random_pre[%0d]: got %h expected %h", i, obs_vec, model_vec());
            end
            clock_op();
            n_tests++;
            if (obs_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL random_post[%0d]: got %h expected %h", i, obs_vec, model_vec());
            end
        end
    endtask

    task automatic test_reset_midop();
        drive(CSR_OP_WRITE, 12'h802, 32'hDEAD, CSR_OP_WRITE, 12'h801, 32'hBEEF);
        rst_i = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if (obs_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected %h", obs_vec, model_vec());
        end
        @(posedge clk_i);
        @(negedge clk_i);
        n_tests++;
        if (obs_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL reset_midop: got %h expected %h", obs_vec, model_vec());
        end
        rst_i = 1'b0;
        drive(CSR_OP_WRITE, 12'h803, 32'h44, CSR_OP_NONE, 12'h0, 32'h0);
        clock_op();
        n_tests++;
        if (csr_a_rstn_o !== 1'b1 || csr_w_rstn_o !== 1'b0 || obs_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL reset_release_write: got %h expected %h", obs_vec, model_vec());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
